// File: rtl/closest_hit_resolver.sv
// Closest-hit resolver: per-lane result FIFOs, tag alignment, nearest-hit
// selection and raster-ordered pixel output over a valid/ready handshake.

`ifndef TAG_SIZE
`define TAG_SIZE 4
`endif

package closest_hit_resolver_pkg;

  localparam int unsigned TMIN_WIDTH    = 16;
  localparam int unsigned CHANNEL_WIDTH = 8;

  typedef struct packed {
    logic [CHANNEL_WIDTH-1:0] r;
    logic [CHANNEL_WIDTH-1:0] g;
    logic [CHANNEL_WIDTH-1:0] b;
  } color_t;

  typedef struct packed {
    color_t color;
  } box_t;

  typedef struct packed {
    logic                  ray_hit;
    logic [TMIN_WIDTH-1:0] tmin;
    box_t                  box;
  } aabb_result_t;

endpackage

module closest_hit_resolver
  import closest_hit_resolver_pkg::*;
#(
  parameter int unsigned      WIDTH        = TMIN_WIDTH,
  parameter int unsigned      Q_BITS       = 12,
  parameter logic [WIDTH-1:0] MAX          = WIDTH'(16'h7FFF),
  parameter int unsigned      OBJECT_COUNT = 3,
  parameter int unsigned      TAG_SIZE     = `TAG_SIZE,
  parameter int unsigned      FIFO_DEPTH   = 4,
  parameter int unsigned      PIXEL_WIDTH  = 640,
  parameter int unsigned      PIXEL_HEIGHT = 480,
  parameter color_t           BG_COLOR     = '{r: 8'd0, g: 8'd0, b: 8'd0}
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              valid_in  [OBJECT_COUNT],
  input  aabb_result_t                      result_in [OBJECT_COUNT],
  input  logic [TAG_SIZE-1:0]               tag_in    [OBJECT_COUNT],
  output logic                              in_ready,
  output logic                              pixel_valid,
  input  logic                              pixel_ready,
  output color_t                            pixel_color,
  output logic [WIDTH-1:0]                  pixel_tmin,
  output logic [$clog2(PIXEL_WIDTH)-1:0]    pixel_x,
  output logic [$clog2(PIXEL_HEIGHT)-1:0]   pixel_y,
  output logic                              frame_done,
  output logic                              overflow_err,
  output logic                              tag_err
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned X_W   = $clog2(PIXEL_WIDTH);
  localparam int unsigned Y_W   = $clog2(PIXEL_HEIGHT);

  // Elaboration-time sanity of the parameter set.
  if (WIDTH != TMIN_WIDTH || Q_BITS >= WIDTH || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || PIXEL_WIDTH < 2 || PIXEL_HEIGHT < 2)
  begin : g_param_check
    $error("closest_hit_resolver: unsupported parameter combination");
  end

  aabb_result_t          res_mem [OBJECT_COUNT][FIFO_DEPTH];
  logic [TAG_SIZE-1:0]   tag_mem [OBJECT_COUNT][FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr  [OBJECT_COUNT];
  logic [PTR_W-1:0]      rd_ptr  [OBJECT_COUNT];
  logic [CNT_W-1:0]      count   [OBJECT_COUNT];

  logic [OBJECT_COUNT-1:0] lane_full_c;
  logic [OBJECT_COUNT-1:0] lane_empty_c;
  logic [OBJECT_COUNT-1:0] tag_ok_c;
  logic [OBJECT_COUNT-1:0] pop_c;
  logic [OBJECT_COUNT-1:0] push_ok_c;
  logic                    overflow_c;

  logic                    out_free_c;
  logic                    resolve_c;
  logic                    load_c;
  logic                    discard_c;

  logic                    best_hit_c;
  logic [WIDTH-1:0]        best_tmin_c;
  color_t                  best_color_c;

  logic [TAG_SIZE-1:0]     expected_tag;
  logic [X_W-1:0]          x_cnt;
  logic [Y_W-1:0]          y_cnt;

  // Lane occupancy and head-tag match against the ray being assembled.
  always_comb begin
    lane_full_c  = '0;
    lane_empty_c = '0;
    tag_ok_c     = '0;
    for (int i = 0; i < OBJECT_COUNT; i++) begin
      lane_full_c[i]  = (count[i] == CNT_W'(FIFO_DEPTH));
      lane_empty_c[i] = (count[i] == '0);
      tag_ok_c[i]     = (tag_mem[i][rd_ptr[i]] == expected_tag);
    end
  end

  assign in_ready   = ~|lane_full_c;
  assign out_free_c = !pixel_valid || pixel_ready;
  assign resolve_c  = (~|lane_empty_c) && out_free_c;
  assign load_c     = resolve_c && (&tag_ok_c);
  assign discard_c  = resolve_c && !(&tag_ok_c);

  // Pops: all lanes on a good resolve, only the stale heads on a tag mismatch.
  always_comb begin
    pop_c      = '0;
    push_ok_c  = '0;
    overflow_c = 1'b0;
    if (load_c) begin
      pop_c = '1;
    end else if (discard_c) begin
      pop_c = ~tag_ok_c;
    end
    for (int i = 0; i < OBJECT_COUNT; i++) begin
      push_ok_c[i] = valid_in[i] && (!lane_full_c[i] || pop_c[i]);
      if (valid_in[i] && lane_full_c[i] && !pop_c[i]) begin
        overflow_c = 1'b1;
      end
    end
  end

  // Nearest hit across lane heads; strict compare keeps the lowest lane on ties.
  always_comb begin
    best_hit_c   = 1'b0;
    best_tmin_c  = MAX;
    best_color_c = BG_COLOR;
    for (int i = 0; i < OBJECT_COUNT; i++) begin
      if (res_mem[i][rd_ptr[i]].ray_hit &&
          (!best_hit_c || $signed(res_mem[i][rd_ptr[i]].tmin) < $signed(best_tmin_c))) begin
        best_hit_c   = 1'b1;
        best_tmin_c  = WIDTH'(res_mem[i][rd_ptr[i]].tmin);
        best_color_c = res_mem[i][rd_ptr[i]].box.color;
      end
    end
  end

  // FIFO storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    for (int i = 0; i < OBJECT_COUNT; i++) begin
      if (push_ok_c[i]) begin
        res_mem[i][wr_ptr[i]] <= result_in[i];
        tag_mem[i][wr_ptr[i]] <= tag_in[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < OBJECT_COUNT; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < OBJECT_COUNT; i++) begin
        if (push_ok_c[i]) begin
          wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
        end
        if (pop_c[i]) begin
          rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
        end
        case ({push_ok_c[i], pop_c[i]})
          2'b10:   count[i] <= count[i] + CNT_W'(1);
          2'b01:   count[i] <= count[i] - CNT_W'(1);
          default: count[i] <= count[i];
        endcase
      end
    end
  end

  // Output register, raster counters, ray tag sequence and sticky errors.
  always_ff @(posedge clk) begin
    if (reset) begin
      pixel_valid  <= 1'b0;
      pixel_color  <= '0;
      pixel_tmin   <= '0;
      pixel_x      <= '0;
      pixel_y      <= '0;
      x_cnt        <= '0;
      y_cnt        <= '0;
      expected_tag <= '0;
      overflow_err <= 1'b0;
      tag_err      <= 1'b0;
    end else begin
      if (overflow_c) begin
        overflow_err <= 1'b1;
      end
      if (discard_c) begin
        tag_err <= 1'b1;
      end
      if (load_c) begin
        pixel_valid  <= 1'b1;
        pixel_color  <= best_color_c;
        pixel_tmin   <= best_tmin_c;
        pixel_x      <= x_cnt;
        pixel_y      <= y_cnt;
        expected_tag <= expected_tag + TAG_SIZE'(1);
        if (x_cnt == X_W'(PIXEL_WIDTH - 1)) begin
          x_cnt <= '0;
          y_cnt <= (y_cnt == Y_W'(PIXEL_HEIGHT - 1)) ? '0 : y_cnt + Y_W'(1);
        end else begin
          x_cnt <= x_cnt + X_W'(1);
        end
      end else if (pixel_ready) begin
        pixel_valid <= 1'b0;
      end
    end
  end

  // Same-cycle pulse as the handshake that retires the frame's last pixel.
  assign frame_done = pixel_valid && pixel_ready &&
                      (pixel_x == X_W'(PIXEL_WIDTH - 1)) &&
                      (pixel_y == Y_W'(PIXEL_HEIGHT - 1));

endmodule

// File: tb/tb_closest_hit_resolver.sv
// Bench for closest_hit_resolver: directed table, backpressure/tag/frame/reset
// sequences and a randomized run scored against a transaction-level model.

module tb_closest_hit_resolver;
  import closest_hit_resolver_pkg::*;

  localparam int NL    = 3;
  localparam int TW    = 4;
  localparam int PW    = 4;
  localparam int PH    = 2;
  localparam int DEPTH = 4;
  localparam int NRAND = 40;

  typedef struct packed {
    color_t      color;
    logic [15:0] tmin;
    logic [1:0]  x;
    logic [0:0]  y;
  } pix_t;

  typedef struct {
    aabb_result_t [NL-1:0] res;
    color_t                exp_color;
    logic [15:0]           exp_tmin;
  } vec_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         valid_in  [NL];
  aabb_result_t result_in [NL];
  logic [TW-1:0] tag_in   [NL];
  logic         in_ready;
  logic         pixel_valid;
  logic         pixel_ready;
  color_t       pixel_color;
  logic [15:0]  pixel_tmin;
  logic [1:0]   pixel_x;
  logic [0:0]   pixel_y;
  logic         frame_done;
  logic         overflow_err;
  logic         tag_err;

  closest_hit_resolver #(
    .OBJECT_COUNT(NL), .TAG_SIZE(TW), .FIFO_DEPTH(DEPTH),
    .PIXEL_WIDTH(PW), .PIXEL_HEIGHT(PH)
  ) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .result_in(result_in),
    .tag_in(tag_in), .in_ready(in_ready), .pixel_valid(pixel_valid),
    .pixel_ready(pixel_ready), .pixel_color(pixel_color), .pixel_tmin(pixel_tmin),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .frame_done(frame_done),
    .overflow_err(overflow_err), .tag_err(tag_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int next_tag = 0;
  int pix_idx = 0;
  int fd_count = 0;
  int acc_count = 0;
  pix_t exp_q[$];
  vec_t vecs [6];
  aabb_result_t [NL-1:0] rnd_rays [NRAND];
  int pushed [NL];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic aabb_result_t mk(input bit hit, input logic [15:0] t, input color_t c);
    aabb_result_t r;
    r.ray_hit   = hit;
    r.tmin      = t;
    r.box.color = c;
    return r;
  endfunction

  function automatic aabb_result_t gen_ray();
    logic [15:0] t;
    t = ($urandom_range(0, 3) == 0) ? 16'h0800 : 16'($urandom);
    return mk($urandom_range(0, 3) != 0, t, 24'($urandom));
  endfunction

  function automatic vec_t mkv(input aabb_result_t a, input aabb_result_t b, input aabb_result_t c,
                               input color_t ec, input logic [15:0] et);
    vec_t v;
    v.res[0] = a; v.res[1] = b; v.res[2] = c;
    v.exp_color = ec; v.exp_tmin = et;
    return v;
  endfunction

  // Reference: smallest signed distance among hits, then the first lane holding it.
  function automatic pix_t model(input aabb_result_t [NL-1:0] res);
    pix_t p;
    int   mn;
    bit   any;
    p = '0; p.tmin = 16'h7FFF; mn = 0; any = 1'b0;
    for (int i = 0; i < NL; i++) begin
      if (res[i].ray_hit) begin
        if (!any || int'($signed(res[i].tmin)) < mn) mn = int'($signed(res[i].tmin));
        any = 1'b1;
      end
    end
    for (int i = NL - 1; i >= 0; i--) begin
      if (any && res[i].ray_hit && int'($signed(res[i].tmin)) == mn) begin
        p.color = res[i].box.color;
        p.tmin  = res[i].tmin;
      end
    end
    return p;
  endfunction

  function automatic pix_t place(input pix_t p, input int k);
    pix_t q;
    q = p;
    q.x = 2'(k % PW);
    q.y = 1'((k / PW) % PH);
    return q;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    for (int i = 0; i < NL; i++) begin
      valid_in[i] = 1'b0; result_in[i] = '0; tag_in[i] = '0;
    end
  endtask

  task automatic push_ray(input aabb_result_t [NL-1:0] res, input bit keep, input bit use_tbl,
                          input color_t tc, input logic [15:0] tt);
    pix_t p;
    for (int i = 0; i < NL; i++) begin
      valid_in[i] = 1'b1; result_in[i] = res[i]; tag_in[i] = TW'(next_tag);
    end
    if (keep) begin
      p = model(res);
      if (use_tbl) begin
        p.color = tc; p.tmin = tt;
      end
      exp_q.push_back(place(p, pix_idx));
      next_tag++;
      pix_idx++;
    end
  endtask

  // Score any pixel handed over at the coming edge.
  task automatic observe;
    pix_t e;
    #2;
    if (pixel_valid && pixel_ready) begin
      acc_count++;
      if (exp_q.size() == 0) begin
        check("unexpected_pixel", 32'(exp_q.size()), 1);
      end else begin
        e = exp_q.pop_front();
        check("pix_color", pixel_color, e.color);
        check("pix_tmin", pixel_tmin, e.tmin);
        check("pix_x", pixel_x, e.x);
        check("pix_y", pixel_y, e.y);
        check("frame_done", frame_done, (e.x == 2'(PW - 1)) && (e.y == 1'(PH - 1)));
        if (frame_done) fd_count++;
      end
    end else begin
      check("frame_done_idle", frame_done, 0);
    end
  endtask

  task automatic step;
    observe();
    tick();
  endtask

  task automatic drain(input int max_cycles);
    idle();
    for (int c = 0; c < max_cycles && exp_q.size() > 0; c++) step();
    check("drain_left", 32'(exp_q.size()), 0);
  endtask

  task automatic do_reset;
    reset = 1'b1;
    idle();
    pixel_ready = 1'b0;
    tick();
    check("rst_valid", pixel_valid, 0);
    check("rst_color", pixel_color, 0);
    check("rst_tmin", pixel_tmin, 0);
    check("rst_x", pixel_x, 0);
    check("rst_y", pixel_y, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_overflow", overflow_err, 0);
    check("rst_tag_err", tag_err, 0);
    check("rst_in_ready", in_ready, 1);
    reset = 1'b0;
    exp_q.delete();
    next_tag = 0; pix_idx = 0; fd_count = 0; acc_count = 0;
  endtask

  initial begin
    aabb_result_t [NL-1:0] res;
    pixel_ready = 1'b0;
    idle();

    vecs[0] = mkv(mk(1, 16'h3000, 24'hFF0000), mk(1, 16'h1000, 24'h00FF00),
                  mk(1, 16'h2000, 24'h0000FF), 24'h00FF00, 16'h1000);
    vecs[1] = mkv(mk(0, 16'h0100, 24'hFF0000), mk(0, 16'h0200, 24'h00FF00),
                  mk(0, 16'h0300, 24'h0000FF), 24'h000000, 16'h7FFF);
    vecs[2] = mkv(mk(1, 16'h1800, 24'hFF0000), mk(0, 16'h0100, 24'h00FF00),
                  mk(1, 16'h1800, 24'h0000FF), 24'hFF0000, 16'h1800);
    vecs[3] = mkv(mk(1, 16'h0100, 24'hFF0000), mk(1, 16'hF000, 24'h00FF00),
                  mk(1, 16'h0010, 24'h0000FF), 24'h00FF00, 16'hF000);
    vecs[4] = mkv(mk(0, 16'h0001, 24'hFF0000), mk(0, 16'h0002, 24'h00FF00),
                  mk(1, 16'h7000, 24'h123456), 24'h123456, 16'h7000);
    vecs[5] = mkv(mk(1, 16'h0500, 24'hFF0000), mk(1, 16'h0400, 24'h00FF00),
                  mk(1, 16'h0400, 24'h0000FF), 24'h00FF00, 16'h0400);

    // Directed table: one ray at a time, pixel one cycle after the FIFO write.
    do_reset();
    pixel_ready = 1'b1;
    for (int v = 0; v < 6; v++) begin
      push_ray(vecs[v].res, 1'b1, 1'b1, vecs[v].exp_color, vecs[v].exp_tmin);
      step();
      idle();
      check("latency_gap", pixel_valid, 0);
      step();
      check("latency_valid", pixel_valid, 1);
    end
    drain(10);

    // Backpressure: fill to full, overflow on the extra ray, fields held.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < NL; i++)
        res[i] = mk(i == (k % NL), 16'(16'h0100 * (k + 1)), 24'(24'h111111 * (k + 1)));
      if (k == 4) check("in_ready_not_full", in_ready, 1);
      push_ray(res, 1'b1, 1'b0, '0, '0);
      step();
    end
    idle();
    check("in_ready_full", in_ready, 0);
    push_ray(res, 1'b0, 1'b0, '0, '0);
    step();
    idle();
    check("overflow_err", overflow_err, 1);
    check("in_ready_still_full", in_ready, 0);
    for (int c = 0; c < 6; c++) begin
      check("hold_valid", pixel_valid, 1);
      check("hold_color", pixel_color, exp_q[0].color);
      check("hold_tmin", pixel_tmin, exp_q[0].tmin);
      check("hold_x", pixel_x, exp_q[0].x);
      step();
    end
    pixel_ready = 1'b1;
    drain(40);

    // Stray tag on lane 1 ahead of the expected ray.
    idle();
    valid_in[1] = 1'b1;
    result_in[1] = mk(1, 16'h0000, 24'hFFFFFF);
    tag_in[1] = TW'(next_tag + 5);
    step();
    res[0] = mk(1, 16'h0200, 24'h00AA00);
    res[1] = mk(1, 16'h0300, 24'hAA0000);
    res[2] = mk(0, 16'h0001, 24'h0000AA);
    push_ray(res, 1'b1, 1'b0, '0, '0);
    step();
    idle();
    step();
    check("tag_err", tag_err, 1);
    check("tag_no_pixel", pixel_valid, 0);
    drain(10);

    // Full frame plus wrap, then reset with a pixel held.
    do_reset();
    pixel_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      for (int i = 0; i < NL; i++) res[i] = gen_ray();
      push_ray(res, 1'b1, 1'b0, '0, '0);
      step();
    end
    drain(30);
    check("frame_done_count", 32'(fd_count), 1);
    pixel_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < NL; i++) res[i] = gen_ray();
      push_ray(res, 1'b1, 1'b0, '0, '0);
      step();
    end
    idle();
    step();
    check("pre_reset_valid", pixel_valid, 1);
    do_reset();
    for (int i = 0; i < NL; i++) res[i] = gen_ray();
    push_ray(res, 1'b1, 1'b0, '0, '0);
    pixel_ready = 1'b1;
    step();
    drain(10);

    // Randomized lanes with independent latencies and random backpressure.
    do_reset();
    for (int n = 0; n < NRAND; n++) begin
      for (int i = 0; i < NL; i++) rnd_rays[n][i] = gen_ray();
      exp_q.push_back(place(model(rnd_rays[n]), n));
    end
    for (int i = 0; i < NL; i++) pushed[i] = 0;
    for (int c = 0; c < 4000 && exp_q.size() > 0; c++) begin
      idle();
      pixel_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NL; i++) begin
        if (pushed[i] < NRAND && (pushed[i] - acc_count) < DEPTH && $urandom_range(0, 2) != 0) begin
          valid_in[i]  = 1'b1;
          result_in[i] = rnd_rays[pushed[i]][i];
          tag_in[i]    = TW'(pushed[i]);
          pushed[i]++;
        end
      end
      step();
    end
    check("rand_remaining", 32'(exp_q.size()), 0);
    check("rand_frames", 32'(fd_count), NRAND / (PW * PH));
    check("rand_overflow", overflow_err, 0);
    check("rand_tag_err", tag_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
